// File: rtl/writeback_arbiter.sv
// Writeback arbiter: three per-source result queues (ALU, LOAD, BRANCH) drained one entry per
// cycle onto a registered common data bus under round-robin arbitration.
module writeback_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ROB_WIDTH  = 5,
    parameter int unsigned PHY_WIDTH  = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,

    input  logic                  alu_valid_i,
    input  logic [ROB_WIDTH-1:0]  alu_rob_id_i,
    input  logic [PHY_WIDTH-1:0]  alu_rd_phy_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,

    input  logic                  ld_valid_i,
    input  logic [ROB_WIDTH-1:0]  ld_rob_id_i,
    input  logic [PHY_WIDTH-1:0]  ld_rd_phy_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,

    input  logic                  br_valid_i,
    input  logic [ROB_WIDTH-1:0]  br_rob_id_i,
    input  logic [PHY_WIDTH-1:0]  br_rd_phy_i,
    input  logic [DATA_WIDTH-1:0] br_link_i,
    input  logic                  br_taken_i,
    input  logic [ADDR_WIDTH-1:0] br_target_i,

    output logic                  alu_ready_o,
    output logic                  ld_ready_o,
    output logic                  br_ready_o,

    output logic                  cdb_valid_o,
    output logic [ROB_WIDTH-1:0]  cdb_rob_id_o,
    output logic [PHY_WIDTH-1:0]  cdb_rd_phy_o,
    output logic [DATA_WIDTH-1:0] cdb_data_o,
    output logic                  cdb_prf_we_o,
    output logic                  cdb_is_branch_o,
    output logic                  cdb_taken_o,
    output logic [ADDR_WIDTH-1:0] cdb_target_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [ROB_WIDTH-1:0]  rob;
        logic [PHY_WIDTH-1:0]  phy;
        logic [DATA_WIDTH-1:0] data;
        logic                  taken;
        logic [ADDR_WIDTH-1:0] target;
    } entry_t;

    entry_t          mem_q    [3][FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q [3];
    logic [PtrW-1:0] wr_ptr_d [3];
    logic [PtrW-1:0] rd_ptr_q [3];
    logic [PtrW-1:0] rd_ptr_d [3];
    logic [CntW-1:0] count_q  [3];
    logic [CntW-1:0] count_d  [3];
    logic [1:0]      rr_ptr_q, rr_ptr_d;

    entry_t          in_entry [3];
    logic [2:0]      in_valid, ready, push, pop;
    logic            gnt_valid;
    logic [1:0]      gnt_idx;
    logic [2:0]      cand;
    entry_t          head;

    always_comb begin
        in_valid    = {br_valid_i, ld_valid_i, alu_valid_i};
        in_entry[0] = '{rob: alu_rob_id_i, phy: alu_rd_phy_i, data: alu_result_i,
                        taken: 1'b0, target: '0};
        in_entry[1] = '{rob: ld_rob_id_i, phy: ld_rd_phy_i, data: ld_data_i,
                        taken: 1'b0, target: '0};
        in_entry[2] = '{rob: br_rob_id_i, phy: br_rd_phy_i, data: br_link_i,
                        taken: br_taken_i, target: br_target_i};
    end

    // Ready depends only on registered occupancy, so a full queue stays closed even if it pops.
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            ready[s] = (count_q[s] != CntW'(FIFO_DEPTH));
            push[s]  = in_valid[s] && ready[s] && !flush_i;
        end
    end

    assign alu_ready_o = ready[0];
    assign ld_ready_o  = ready[1];
    assign br_ready_o  = ready[2];

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!gnt_valid && count_q[cand[1:0]] != '0) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[1:0];
            end
        end
        head = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_valid) rr_ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        for (int s = 0; s < 3; s++) begin
            pop[s]      = gnt_valid && (gnt_idx == 2'(s)) && !flush_i;
            wr_ptr_d[s] = push[s] ? wr_ptr_q[s] + PtrW'(1) : wr_ptr_q[s];
            rd_ptr_d[s] = pop[s] ? rd_ptr_q[s] + PtrW'(1) : rd_ptr_q[s];
            count_d[s]  = count_q[s] + CntW'(push[s]) - CntW'(pop[s]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rr_ptr_q <= 2'd0;
            for (int s = 0; s < 3; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int s = 0; s < 3; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                count_q[s]  <= count_d[s];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 3; s++) begin
            if (push[s] && !rst_i) mem_q[s][wr_ptr_q[s]] <= in_entry[s];
        end
    end

    // Idle bus carries an all-zero payload; branch fields are zero for non-branch sources.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || !gnt_valid) begin
            cdb_valid_o     <= 1'b0;
            cdb_rob_id_o    <= '0;
            cdb_rd_phy_o    <= '0;
            cdb_data_o      <= '0;
            cdb_prf_we_o    <= 1'b0;
            cdb_is_branch_o <= 1'b0;
            cdb_taken_o     <= 1'b0;
            cdb_target_o    <= '0;
        end else begin
            cdb_valid_o     <= 1'b1;
            cdb_rob_id_o    <= head.rob;
            cdb_rd_phy_o    <= head.phy;
            cdb_data_o      <= head.data;
            cdb_prf_we_o    <= (head.phy != '0);
            cdb_is_branch_o <= (gnt_idx == 2'd2);
            cdb_taken_o     <= head.taken;
            cdb_target_o    <= head.target;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios then random traffic, all checked against a
// queue-based reference model of the arbiter.
module tb_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        alu_valid, ld_valid, br_valid, br_taken;
    logic [4:0]  alu_rob, ld_rob, br_rob;
    logic [5:0]  alu_rd, ld_rd, br_rd;
    logic [31:0] alu_result, ld_data, br_link, br_target;
    logic        alu_ready, ld_ready, br_ready;
    logic        cdb_valid, cdb_prf_we, cdb_is_branch, cdb_taken;
    logic [4:0]  cdb_rob;
    logic [5:0]  cdb_rd;
    logic [31:0] cdb_data, cdb_target;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .ROB_WIDTH(5), .PHY_WIDTH(6), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .alu_valid_i(alu_valid), .alu_rob_id_i(alu_rob), .alu_rd_phy_i(alu_rd),
        .alu_result_i(alu_result),
        .ld_valid_i(ld_valid), .ld_rob_id_i(ld_rob), .ld_rd_phy_i(ld_rd), .ld_data_i(ld_data),
        .br_valid_i(br_valid), .br_rob_id_i(br_rob), .br_rd_phy_i(br_rd), .br_link_i(br_link),
        .br_taken_i(br_taken), .br_target_i(br_target),
        .alu_ready_o(alu_ready), .ld_ready_o(ld_ready), .br_ready_o(br_ready),
        .cdb_valid_o(cdb_valid), .cdb_rob_id_o(cdb_rob), .cdb_rd_phy_o(cdb_rd),
        .cdb_data_o(cdb_data), .cdb_prf_we_o(cdb_prf_we), .cdb_is_branch_o(cdb_is_branch),
        .cdb_taken_o(cdb_taken), .cdb_target_o(cdb_target)
    );

    typedef struct {
        logic [4:0]  rob;
        logic [5:0]  rd;
        logic [31:0] data;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t q_alu[$], q_ld[$], q_br[$];
    int   rr;
    ent_t exp_e;
    logic exp_valid, exp_br;
    int   n_cmp = 0;
    int   n_fail = 0;

    function automatic int qsize(int s);
        case (s)
            0: return q_alu.size();
            1: return q_ld.size();
            default: return q_br.size();
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the arbiter, described as queue operations.
    task automatic model_step();
        bit acc[3];
        int g;
        ent_t e;
        exp_valid = 1'b0;
        exp_br    = 1'b0;
        exp_e     = '{rob: '0, rd: '0, data: '0, taken: 1'b0, target: '0};
        if (rst || flush) begin
            q_alu.delete(); q_ld.delete(); q_br.delete();
            rr = 0;
            return;
        end
        for (int s = 0; s < 3; s++) acc[s] = qsize(s) < DEPTH;
        g = -1;
        for (int k = 0; k < 3; k++) begin
            if (g < 0 && qsize((rr + k) % 3) > 0) g = (rr + k) % 3;
        end
        if (g >= 0) begin
            case (g)
                0: exp_e = q_alu.pop_front();
                1: exp_e = q_ld.pop_front();
                default: exp_e = q_br.pop_front();
            endcase
            exp_valid = 1'b1;
            exp_br    = (g == 2);
            rr        = (g + 1) % 3;
        end
        if (alu_valid && acc[0]) begin
            e = '{rob: alu_rob, rd: alu_rd, data: alu_result, taken: 1'b0, target: '0};
            q_alu.push_back(e);
        end
        if (ld_valid && acc[1]) begin
            e = '{rob: ld_rob, rd: ld_rd, data: ld_data, taken: 1'b0, target: '0};
            q_ld.push_back(e);
        end
        if (br_valid && acc[2]) begin
            e = '{rob: br_rob, rd: br_rd, data: br_link, taken: br_taken, target: br_target};
            q_br.push_back(e);
        end
    endtask

    task automatic check_outputs();
        chk("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
        chk("cdb_rob_id", 64'(cdb_rob), 64'(exp_e.rob));
        chk("cdb_rd_phy", 64'(cdb_rd), 64'(exp_e.rd));
        chk("cdb_data", 64'(cdb_data), 64'(exp_e.data));
        chk("cdb_prf_we", 64'(cdb_prf_we), 64'(exp_valid && exp_e.rd != 0));
        chk("cdb_is_branch", 64'(cdb_is_branch), 64'(exp_br));
        chk("cdb_taken", 64'(cdb_taken), 64'(exp_e.taken));
        chk("cdb_target", 64'(cdb_target), 64'(exp_e.target));
        chk("alu_ready", 64'(alu_ready), 64'(q_alu.size() != DEPTH));
        chk("ld_ready", 64'(ld_ready), 64'(q_ld.size() != DEPTH));
        chk("br_ready", 64'(br_ready), 64'(q_br.size() != DEPTH));
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0;
        alu_valid = 1'b0; alu_rob = '0; alu_rd = '0; alu_result = '0;
        ld_valid = 1'b0; ld_rob = '0; ld_rd = '0; ld_data = '0;
        br_valid = 1'b0; br_rob = '0; br_rd = '0; br_link = '0; br_taken = 1'b0;
        br_target = '0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        idle();
    endtask

    task automatic put_alu(logic [4:0] rob, logic [5:0] rd, logic [31:0] v);
        alu_valid = 1'b1; alu_rob = rob; alu_rd = rd; alu_result = v;
    endtask

    task automatic put_ld(logic [4:0] rob, logic [5:0] rd, logic [31:0] v);
        ld_valid = 1'b1; ld_rob = rob; ld_rd = rd; ld_data = v;
    endtask

    task automatic put_br(logic [4:0] rob, logic [5:0] rd, logic [31:0] link, logic tk,
                          logic [31:0] tgt);
        br_valid = 1'b1; br_rob = rob; br_rd = rd; br_link = link; br_taken = tk;
        br_target = tgt;
    endtask

    initial begin
        idle();
        rst = 1'b1; step();
        rst = 1'b1; step();

        // Single ALU push reaches the bus one cycle later, then the bus goes idle.
        put_alu(5'd3, 6'd7, 32'h55); step();
        step();
        step();

        // Simultaneous offers from all three sources out of reset.
        rst = 1'b1; step();
        put_alu(5'd1, 6'd10, 32'hA1);
        put_ld(5'd2, 6'd11, 32'hB2);
        put_br(5'd4, 6'd12, 32'h1004, 1'b1, 32'hDEAD_BEE0);
        step();
        repeat (4) step();

        // Five back-to-back ALU pushes.
        for (int i = 0; i < 5; i++) begin
            put_alu(5'(i + 8), 6'(i + 1), 32'h100 + 32'(i)); step();
        end
        repeat (3) step();

        // Load to physical register zero must not write the register file.
        put_ld(5'd9, 6'd0, 32'hCAFE); step();
        repeat (2) step();

        // ALU and LOAD pushing together fill the ALU queue; refused offers vanish.
        for (int i = 0; i < 10; i++) begin
            put_alu(5'(i), 6'(i + 20), 32'h200 + 32'(i));
            put_ld(5'(i + 16), 6'(i + 40), 32'h300 + 32'(i));
            step();
        end
        repeat (12) step();

        // Flush with entries buffered in two queues.
        for (int i = 0; i < 2; i++) begin
            put_alu(5'(i), 6'(i + 1), 32'hF00 + 32'(i));
            put_ld(5'(i + 4), 6'(i + 5), 32'hE00 + 32'(i));
            step();
        end
        flush = 1'b1; step();
        repeat (3) step();

        // Reset while busy, then ALU wins against BRANCH.
        for (int i = 0; i < 3; i++) begin
            put_alu(5'(i), 6'(i + 1), 32'hA00 + 32'(i));
            put_ld(5'(i + 4), 6'(i + 5), 32'hB00 + 32'(i));
            step();
        end
        rst = 1'b1; step();
        put_alu(5'd5, 6'd6, 32'h77);
        put_br(5'd6, 6'd8, 32'h2000, 1'b0, 32'h1234);
        step();
        repeat (3) step();

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(99) < 60)
                put_alu(5'($urandom), ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom), $urandom);
            if ($urandom_range(99) < 50)
                put_ld(5'($urandom), ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom), $urandom);
            if ($urandom_range(99) < 45)
                put_br(5'($urandom), 6'($urandom), $urandom, 1'($urandom), $urandom);
            flush = ($urandom_range(49) == 0);
            rst   = ($urandom_range(149) == 0);
            step();
        end
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, result/data width.
REQ-002 Parameter ADDR_WIDTH, 32, branch target width.
REQ-003 Parameter ROB_WIDTH, 5, ROB tag width.
REQ-004 Parameter PHY_WIDTH, 6, physical register index width.
REQ-005 Parameter FIFO_DEPTH, 4, entries per source queue, power of two, >=2.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 flush  in  1  mispredict/exception flush; discards all buffered results.
REQ-009 alu_valid, alu_rob_id, alu_rd_phy, alu_result  in  1/ROB_WIDTH/PHY_WIDTH/DATA_WIDTH  ALU result offer.
REQ-010 ld_valid, ld_rob_id, ld_rd_phy, ld_data  in  1/ROB_WIDTH/PHY_WIDTH/DATA_WIDTH  load-return offer.
REQ-011 br_valid, br_rob_id, br_rd_phy, br_link, br_taken, br_target  in  1/ROB_WIDTH/PHY_WIDTH/DATA_WIDTH/1/ADDR_WIDTH  branch result offer; br_link is PC+4.
REQ-012 alu_ready, ld_ready, br_ready  out  1 each  source queue can accept this cycle.
REQ-013 cdb_valid  out  1  broadcast valid this cycle.
REQ-014 cdb_rob_id, cdb_rd_phy, cdb_data  out  ROB_WIDTH/PHY_WIDTH/DATA_WIDTH  broadcast payload.
REQ-015 cdb_prf_we  out  1  physical register file write enable.
REQ-016 cdb_is_branch, cdb_taken, cdb_target  out  1/1/ADDR_WIDTH  branch resolution to ROB.

Function
REQ-017 Each source SHALL own a FIFO_DEPTH-entry circular queue with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
REQ-018 x_ready SHALL equal (count_x != FIFO_DEPTH), from registered count only, independent of same-cycle pop.
REQ-019 Push occurs when x_valid && x_ready && !flush; x_valid with x_ready low SHALL be dropped with no state change.
REQ-020 Pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-021 Each cycle at most one non-empty queue SHALL be granted and popped.
REQ-022 Arbitration SHALL be round-robin over ALU(0), LOAD(1), BRANCH(2): search starts at rr_ptr; after a grant rr_ptr becomes grantee+1 mod 3; no grant leaves rr_ptr unchanged.
REQ-023 Granted head SHALL be registered onto the CDB outputs next edge; minimum latency push-to-cdb_valid is 1 cycle, no combinational bypass.
REQ-024 cdb_valid SHALL be high exactly one cycle per popped entry; low when no grant.
REQ-025 cdb_data SHALL be alu_result, ld_data, or br_link according to source.
REQ-026 cdb_prf_we SHALL equal cdb_valid && (cdb_rd_phy != 0).
REQ-027 cdb_is_branch SHALL be 1 only for BRANCH-sourced broadcasts; cdb_taken/cdb_target SHALL be 0 otherwise.
REQ-028 Simultaneous push and pop on one queue SHALL leave count unchanged; both pointers advance.
REQ-029 Push into an empty queue SHALL NOT be granted the same cycle.
REQ-030 flush SHALL, next edge, zero all counts and pointers, set rr_ptr=0, drive cdb_valid=0; flush overrides same-cycle push and pop.
REQ-031 Entries within one source SHALL broadcast in arrival order; no cross-source ordering guarantee.

Reset
REQ-032 On rst high at a rising edge: all counts, pointers, rr_ptr = 0; cdb_valid, cdb_prf_we, cdb_is_branch, cdb_taken = 0; cdb_rob_id, cdb_rd_phy, cdb_data, cdb_target = 0.
REQ-033 rst SHALL take priority over flush and all pushes; in-flight entries are lost.
REQ-034 All x_ready SHALL read 1 in the first cycle after reset release.

Verification
REQ-035 Single ALU push rob=3, rd=7, result=0x55 at cycle N -> cycle N+1 cdb_valid=1, rob=3, rd=7, data=0x55, prf_we=1, is_branch=0; cycle N+2 cdb_valid=0.
REQ-036 All three sources push one entry same cycle from reset -> broadcasts in order ALU, LOAD, BRANCH on three consecutive cycles; branch carries br_link, br_taken, br_target.
REQ-037 Push 5 ALU entries back-to-back, no other traffic, DEPTH=4 -> alu_ready falls after occupancy reaches 4 only if pop rate lags; all accepted entries emerge in order; any offer with alu_ready=0 never appears on CDB.
REQ-038 Load push with rd_phy=0 -> cdb_valid=1, cdb_prf_we=0.
REQ-039 Fill ALU and LOAD queues with 2 entries each, assert flush one cycle -> next cycle cdb_valid=0, all ready=1, no later broadcast of flushed entries.
REQ-040 Assert rst while queues hold entries and cdb_valid=1 -> next cycle all outputs zero, rr_ptr=0; first post-reset grant among simultaneous ALU+BRANCH is ALU.
